// File: rtl/dp_ctrl_pkg.sv
// dp_ctrl_pkg: shared encodings for the single-cycle RISC-V control unit.
// Holds opcode constants, immsel/alusel/wbsel encodings, the sequencer
// state type and the funct3 -> ALU op helper used by the decoder.
package dp_ctrl_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [1:0] WB_MEM = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef enum logic [1:0] {S_EXEC, S_MEM, S_ERR} state_t;

    // alt is inst[30]; it selects SUB only for register-register ops,
    // because an addi immediate can legitimately have bit 30 set.
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt, input logic sub_ok);
        case (f3)
            3'b000:  return (alt && sub_ok) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/dp_ctrl_dec.sv
// dp_ctrl_dec: purely combinational instruction -> datapath control decode.
// Ports: op/f3/alt are inst[6:0], inst[14:12], inst[30]; brlt/breq from the
// branch comparator. Outputs are the raw per-opcode controls plus is_ld/is_st
// and illegal; stall gating is applied by the sequencer in dp_ctrl_fsm.
module dp_ctrl_dec
    import dp_ctrl_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] f3,
    input  logic       alt,
    input  logic       brlt,
    input  logic       breq,
    output logic       pcsel,
    output logic [2:0] immsel,
    output logic       regwen,
    output logic       brun,
    output logic       asel,
    output logic       bsel,
    output logic [3:0] alusel,
    output logic [1:0] wbsel,
    output logic       is_ld,
    output logic       is_st,
    output logic       illegal
);

    always_comb begin
        pcsel   = 1'b0;
        immsel  = IMM_I;
        regwen  = 1'b0;
        brun    = 1'b0;
        asel    = 1'b0;
        bsel    = 1'b0;
        alusel  = ALU_ADD;
        wbsel   = WB_ALU;
        is_ld   = 1'b0;
        is_st   = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_R: begin
                regwen = 1'b1;
                alusel = alu_op(f3, alt, 1'b1);
            end
            OP_I: begin
                bsel   = 1'b1;
                regwen = 1'b1;
                alusel = alu_op(f3, alt, 1'b0);
            end
            OP_LUI: begin
                bsel   = 1'b1;
                immsel = IMM_U;
                alusel = ALU_PASSB;
                regwen = 1'b1;
            end
            OP_AUIPC: begin
                asel   = 1'b1;
                bsel   = 1'b1;
                immsel = IMM_U;
                regwen = 1'b1;
            end
            OP_JAL: begin
                asel   = 1'b1;
                bsel   = 1'b1;
                immsel = IMM_J;
                pcsel  = 1'b1;
                wbsel  = WB_PC4;
                regwen = 1'b1;
            end
            OP_JALR: begin
                bsel   = 1'b1;
                pcsel  = 1'b1;
                wbsel  = WB_PC4;
                regwen = 1'b1;
            end
            OP_BR: begin
                asel   = 1'b1;
                bsel   = 1'b1;
                immsel = IMM_B;
                brun   = f3[1];
                // f3[2] picks the less-than compare, f3[0] inverts the sense
                pcsel  = f3[2] ? (brlt ^ f3[0]) : (breq ^ f3[0]);
            end
            OP_LD: begin
                bsel  = 1'b1;
                wbsel = WB_MEM;
                is_ld = 1'b1;
            end
            OP_ST: begin
                bsel   = 1'b1;
                immsel = IMM_S;
                is_st  = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/dp_ctrl_fsm.sv
// dp_ctrl_fsm: control unit for the single-cycle RISC-V datapath with a
// load/store stall sequencer (S_EXEC / S_MEM / S_ERR) and memory timeout.
// Inputs: clk, rst (sync, active-high), inst, brlt, breq, dmem_ack.
// Outputs: pcsel, immsel, regwen, brun, asel, bsel, alusel, wbsel,
// dmem_req, dmem_we, pc_en, illegal, mem_err (sticky timeout flag).
// Optional: define DP_CTRL_PERF_EN to add cycle_cnt and instret_cnt.
module dp_ctrl_fsm
    import dp_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        brlt,
    input  logic        breq,
    input  logic        dmem_ack,
    output logic        pcsel,
    output logic [2:0]  immsel,
    output logic        regwen,
    output logic        brun,
    output logic        asel,
    output logic        bsel,
    output logic [3:0]  alusel,
    output logic [1:0]  wbsel,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        pc_en,
    output logic        illegal,
    output logic        mem_err
`ifdef DP_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             err_q;
    logic             d_pcsel, d_regwen, d_brun, d_asel, d_bsel, is_ld, is_st, d_illegal;
    logic [2:0]       d_immsel;
    logic [3:0]       d_alusel;
    logic [1:0]       d_wbsel;
    logic             run, exec, in_mem, mem_op, ack_ok, timeout;
    logic             unused_inst;

    assign unused_inst = ^{inst[31], inst[29:15], inst[11:7]};

    dp_ctrl_dec u_dec (
        .op      (inst[6:0]),
        .f3      (inst[14:12]),
        .alt     (inst[30]),
        .brlt    (brlt),
        .breq    (breq),
        .pcsel   (d_pcsel),
        .immsel  (d_immsel),
        .regwen  (d_regwen),
        .brun    (d_brun),
        .asel    (d_asel),
        .bsel    (d_bsel),
        .alusel  (d_alusel),
        .wbsel   (d_wbsel),
        .is_ld   (is_ld),
        .is_st   (is_st),
        .illegal (d_illegal)
    );

    assign run     = !rst;
    assign exec    = state == S_EXEC;
    assign in_mem  = state == S_MEM;
    assign mem_op  = is_ld | is_st;
    assign ack_ok  = in_mem & dmem_ack;
    assign timeout = cnt == CNT_W'(MEM_TIMEOUT);

    // An ack on the timeout cycle still completes the access; S_ERR only leaves on rst.
    always_comb begin
        state_nx = state;
        case (state)
            S_EXEC:  state_nx = mem_op ? S_MEM : S_EXEC;
            S_MEM:   state_nx = dmem_ack ? S_EXEC : (timeout ? S_ERR : S_MEM);
            default: state_nx = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_EXEC;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= in_mem ? cnt + 1'b1 : '0;
            err_q <= err_q | (in_mem & !dmem_ack & timeout);
        end
    end

    // The instruction is held while stalled, so the ALU controls keep the address stable.
    always_comb begin
        pcsel    = run & d_pcsel;
        immsel   = run ? d_immsel : 3'd0;
        brun     = run & d_brun;
        asel     = run & d_asel;
        bsel     = run & d_bsel;
        alusel   = run ? d_alusel : 4'd0;
        wbsel    = run ? d_wbsel : 2'd0;
        regwen   = run & (exec ? d_regwen : ack_ok & is_ld);
        dmem_req = run & mem_op & (exec | in_mem);
        dmem_we  = run & is_st & (exec | in_mem);
        pc_en    = run & (exec ? !mem_op : ack_ok);
        illegal  = run & exec & d_illegal;
        mem_err  = run & err_q;
    end

`ifdef DP_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (pc_en) instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dp_ctrl_fsm.sv
// tb_dp_ctrl_fsm: scoreboard bench for dp_ctrl_fsm with a behavioural model.
module tb_dp_ctrl_fsm;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst = 32'h0000_0013;
    logic        brlt = 1'b0, breq = 1'b0, dmem_ack = 1'b0;
    logic        pcsel, regwen, brun, asel, bsel, dmem_req, dmem_we, pc_en, illegal, mem_err;
    logic [2:0]  immsel;
    logic [3:0]  alusel;
    logic [1:0]  wbsel;
`ifdef DP_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    dp_ctrl_fsm #(.MEM_TIMEOUT(TMO), .CNT_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .inst     (inst),
        .brlt     (brlt),
        .breq     (breq),
        .dmem_ack (dmem_ack),
        .pcsel    (pcsel),
        .immsel   (immsel),
        .regwen   (regwen),
        .brun     (brun),
        .asel     (asel),
        .bsel     (bsel),
        .alusel   (alusel),
        .wbsel    (wbsel),
        .dmem_req (dmem_req),
        .dmem_we  (dmem_we),
        .pc_en    (pc_en),
        .illegal  (illegal),
        .mem_err  (mem_err)
`ifdef DP_CTRL_PERF_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcsel;
        logic [2:0] immsel;
        logic       regwen;
        logic       brun;
        logic       asel;
        logic       bsel;
        logic [3:0] alusel;
        logic [1:0] wbsel;
        logic       dmem_req;
        logic       dmem_we;
        logic       pc_en;
        logic       illegal;
        logic       mem_err;
    } ctl_t;

    typedef struct {
        ctl_t  e;
        ctl_t  m;
        string tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;

    // Reference model state: error latched, waiting on memory, elapsed wait cycles.
    logic m_err  = 1'b0;
    logic m_mem  = 1'b0;
    int   m_wait = 0;

    function automatic logic is_mem(input logic [31:0] i);
        return i[6:0] == 7'b0000011 || i[6:0] == 7'b0100011;
    endfunction

    function automatic logic [3:0] alu_exp(input logic [2:0] f3, input logic i30, input logic r);
        case (f3)
            3'd0:    return (r && i30) ? 4'd1 : 4'd0;
            3'd1:    return 4'd2;
            3'd2:    return 4'd3;
            3'd3:    return 4'd4;
            3'd4:    return 4'd5;
            3'd5:    return i30 ? 4'd7 : 4'd6;
            3'd6:    return 4'd8;
            default: return 4'd9;
        endcase
    endfunction

    function automatic logic br_taken(input logic [2:0] f3, input logic lt, input logic eq);
        case (f3)
            3'd0:       return eq;
            3'd1:       return !eq;
            3'd4, 3'd6: return lt;
            3'd5, 3'd7: return !lt;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic void model(input logic [31:0] i, input logic lt, input logic eq, input logic ack,
                                  input logic r, output ctl_t e, output ctl_t m);
        logic [2:0] f3;
        logic       st;
        f3 = i[14:12];
        st = i[6:0] == 7'b0100011;
        e  = '0;
        m  = '1;
        if (r) return;
        e.mem_err = m_err;
        if (m_err) begin
            m = '0;
            m.pc_en = 1'b1;
            m.regwen = 1'b1;
            m.dmem_req = 1'b1;
            m.illegal = 1'b1;
            m.mem_err = 1'b1;
            return;
        end
        m.brun = 1'b0;
        if (!is_mem(i)) e.pc_en = 1'b1;
        case (i[6:0])
            7'b0110011: begin
                e.regwen = 1'b1; e.wbsel = 2'd1; e.alusel = alu_exp(f3, i[30], 1'b1); m.immsel = '0;
            end
            7'b0010011: begin
                e.bsel = 1'b1; e.regwen = 1'b1; e.wbsel = 2'd1; e.alusel = alu_exp(f3, i[30], 1'b0);
            end
            7'b0110111: begin
                e.bsel = 1'b1; e.immsel = 3'd3; e.alusel = 4'd10; e.wbsel = 2'd1; e.regwen = 1'b1; m.asel = 1'b0;
            end
            7'b0010111: begin
                e.asel = 1'b1; e.bsel = 1'b1; e.immsel = 3'd3; e.wbsel = 2'd1; e.regwen = 1'b1;
            end
            7'b1101111: begin
                e.asel = 1'b1; e.bsel = 1'b1; e.immsel = 3'd4; e.pcsel = 1'b1; e.wbsel = 2'd2; e.regwen = 1'b1;
            end
            7'b1100111: begin
                e.bsel = 1'b1; e.pcsel = 1'b1; e.wbsel = 2'd2; e.regwen = 1'b1;
            end
            7'b1100011: begin
                e.asel = 1'b1; e.bsel = 1'b1; e.immsel = 3'd2; e.brun = f3[1]; m.brun = 1'b1;
                e.pcsel = br_taken(f3, lt, eq); m.wbsel = '0;
            end
            7'b0000011, 7'b0100011: begin
                e.bsel = 1'b1; e.immsel = st ? 3'd1 : 3'd0; e.dmem_req = 1'b1; e.dmem_we = st; m.wbsel = '0;
                if (m_mem && ack) begin
                    e.pc_en = 1'b1;
                    e.regwen = !st;
                    if (!st) m.wbsel = '1;
                end
            end
            default: begin
                m = '0;
                m.pc_en = 1'b1; m.regwen = 1'b1; m.dmem_req = 1'b1; m.illegal = 1'b1; m.mem_err = 1'b1;
                e.illegal = 1'b1;
            end
        endcase
    endfunction

    function automatic void advance(input logic [31:0] i, input logic ack, input logic r);
        if (r) begin
            m_err = 1'b0;
            m_mem = 1'b0;
        end else if (!m_err) begin
            if (m_mem) begin
                if (ack) m_mem = 1'b0;
                else if (m_wait == TMO) begin
                    m_mem = 1'b0;
                    m_err = 1'b1;
                end else m_wait++;
            end else if (is_mem(i)) begin
                m_mem = 1'b1;
                m_wait = 0;
            end
        end
    endfunction

    task automatic step(input logic [31:0] i, input logic lt, input logic eq, input logic ack,
                        input logic r, input string tag);
        exp_t x;
        inst = i; brlt = lt; breq = eq; dmem_ack = ack; rst = r;
        model(i, lt, eq, ack, r, x.e, x.m);
        x.tag = tag;
        q.push_back(x);
        advance(i, ack, r);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_inst(input int k);
        logic [31:0] r;
        logic [2:0]  f3;
        logic [2:0]  bf [6];
        bf = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        r  = $urandom;
        f3 = r[14:12];
        case (k)
            0: return {1'b0, (f3 == 3'd0 || f3 == 3'd5) ? r[30] : 1'b0, 5'b0, r[24:15], f3, r[11:7], 7'b0110011};
            1: return (f3 == 3'd1 || f3 == 3'd5) ? {1'b0, f3 == 3'd5 ? r[30] : 1'b0, 5'b0, r[24:15], f3, r[11:7], 7'b0010011}
                                                 : {r[31:7], 7'b0010011};
            2: return {r[31:7], 7'b0110111};
            3: return {r[31:7], 7'b0010111};
            4: return {r[31:7], 7'b1101111};
            5: return {r[31:15], 3'b000, r[11:7], 7'b1100111};
            6: return {r[31:15], bf[$urandom_range(0, 5)], r[11:7], 7'b1100011};
            7: return {r[31:15], 3'b010, r[11:7], 7'b0000011};
            8: return {r[31:15], 3'b010, r[11:7], 7'b0100011};
            default: case ($urandom_range(0, 3))
                0:       return 32'h0000_007F;
                1:       return {r[31:7], 7'b0000000};
                2:       return {r[31:7], 7'b0001111};
                default: return {r[31:7], 7'b1110011};
            endcase
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t x;
        ctl_t a;
        if (q.size() > 0) begin
            x = q.pop_front();
            a = {pcsel, immsel, regwen, brun, asel, bsel, alusel, wbsel, dmem_req, dmem_we, pc_en, illegal, mem_err};
            checks++;
            if ((a & x.m) === (x.e & x.m)) passed++;
            else $display("FAIL %s: got %h required %h (care mask %h) inst=%h", x.tag, a, x.e, x.m, inst);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] lw, sw, add, nop, bltu, ri;
        int          k, d;
        lw   = 32'h0000_A183;
        sw   = 32'h0020_A223;
        add  = 32'h0020_81B3;
        nop  = 32'h0000_0013;
        bltu = {7'd0, 5'd2, 5'd1, 3'b110, 5'd8, 7'b1100011};
        @(posedge clk);
        #1;
        step(lw, 0, 0, 0, 1, "reset_lw");
        step(nop, 0, 0, 1, 1, "reset");
        step(add, 0, 0, 0, 0, "add");
        step(lw, 0, 0, 0, 0, "lw_exec");
        step(lw, 0, 0, 0, 0, "lw_wait1");
        step(lw, 0, 0, 0, 0, "lw_wait2");
        step(lw, 0, 0, 1, 0, "lw_ack");
        step(sw, 0, 0, 0, 0, "sw_exec");
        step(sw, 0, 0, 1, 0, "sw_ack");
        step(bltu, 1, 0, 0, 0, "bltu_taken");
        step(bltu, 0, 1, 0, 0, "bltu_not_taken");
        step(32'h0000_007F, 0, 0, 0, 0, "illegal");
        step(nop, 0, 0, 0, 0, "after_illegal");
        step(add, 0, 0, 1, 0, "ack_ignored");
        step(lw, 0, 0, 0, 0, "lw_exec_rst");
        step(lw, 0, 0, 0, 0, "lw_wait_rst");
        step(lw, 0, 0, 0, 1, "rst_mid_mem");
        step(add, 0, 0, 0, 0, "after_rst_mid_mem");
        step(lw, 0, 0, 0, 0, "lw_exec_ackmax");
        repeat (TMO) step(lw, 0, 0, 0, 0, "lw_wait_ackmax");
        step(lw, 0, 0, 1, 0, "ack_on_timeout");
        step(add, 0, 0, 0, 0, "after_ack_on_timeout");
        step(lw, 0, 0, 0, 0, "lw_exec_to");
        repeat (TMO + 1) step(lw, 0, 0, 0, 0, "lw_wait_to");
        repeat (3) step(lw, 0, 0, 1, 0, "err_hold");
        step(add, 0, 0, 0, 0, "err_hold_add");
        step(add, 0, 0, 0, 1, "err_rst");
        step(add, 0, 0, 0, 0, "after_err_rst");
        repeat (300) begin
            k  = $urandom_range(0, 10);
            ri = rand_inst(k);
            if (is_mem(ri)) begin
                step(ri, 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0, 0, "rnd_mem_exec");
                d = ($urandom_range(0, 9) == 0) ? TMO : $urandom_range(0, 4);
                for (int n = 0; n < d; n++) step(ri, 1'($urandom), 1'($urandom), 0, 0, "rnd_mem_wait");
                step(ri, 1'($urandom), 1'($urandom), 1, 0, "rnd_mem_ack");
            end else begin
                step(ri, 1'($urandom), 1'($urandom), 1'($urandom), 0, "rnd_exec");
            end
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() == 0) passed++;
        else $display("FAIL drain: %0d expectations left, required 0", q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/dp_ctrl_fsm.md
Name: dp_ctrl_fsm

Overview:
- Control unit for the RISC-V single-cycle datapath.
- Decodes the current instruction into every datapath control: pc select, immediate select, register write enable, compare mode, ALU operand selects, ALU op and write-back select.
- Adds a sequencer that stalls the datapath on loads/stores until a data memory with req/ack handshake responds, with a timeout error.
- Sits beside the datapath and data memory; drives a PC-register enable.

Parameters:
- MEM_TIMEOUT, 16, max cycles spent in S_MEM waiting for dmem_ack before error.
- CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- inst  in  32  current instruction from Imem
- brlt  in  1  comparator less-than
- breq  in  1  comparator equal
- dmem_ack  in  1  data memory access complete, single-cycle pulse
- pcsel  out  1  1 = ALU result, 0 = PC+4
- immsel  out  3  immediate format: I=0, S=1, B=2, U=3, J=4
- regwen  out  1  register file write enable
- brun  out  1  1 = unsigned compare
- asel  out  1  1 = PC, 0 = rs1
- bsel  out  1  1 = immediate, 0 = rs2
- alusel  out  4  ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10
- wbsel  out  2  0 = dmem, 1 = ALU, 2 = PC+4
- dmem_req  out  1  data memory request, level
- dmem_we  out  1  1 = store
- pc_en  out  1  PC register update enable
- illegal  out  1  one-cycle pulse on an unsupported opcode
- mem_err  out  1  sticky timeout flag

Behaviour:
- States: S_EXEC, S_MEM, S_ERR. State register, counter and mem_err are registered; all other outputs are combinational from state and inst.
- Reset (synchronous, active-high): state = S_EXEC, counter = 0, mem_err = 0.
  - While rst is high: pc_en = 0, regwen = 0, dmem_req = 0, illegal = 0.
  - All other outputs are 0 while rst is high.
- Decoding in S_EXEC is by opcode inst[6:0].
- R-type (0110011): bsel = 0, wbsel = 1, regwen = 1.
  - alusel is taken from funct3 and inst[30]: ADD/SUB, SRL/SRA.
- I-ALU (0010011): bsel = 1, immsel = I, wbsel = 1, regwen = 1.
  - Shift ops use inst[30] to pick SRL vs SRA.
- LUI: bsel = 1, immsel = U, alusel = PASSB, wbsel = 1, regwen = 1.
- AUIPC: asel = 1, bsel = 1, immsel = U, alusel = ADD, wbsel = 1, regwen = 1.
- JAL: asel = 1, bsel = 1, immsel = J, ADD, pcsel = 1, wbsel = 2, regwen = 1.
- JALR: bsel = 1, immsel = I, ADD, pcsel = 1, wbsel = 2, regwen = 1.
- BRANCH: asel = 1, bsel = 1, immsel = B, ADD, brun = funct3[1], regwen = 0.
  - pcsel = taken: BEQ = breq, BNE = !breq, BLT/BLTU = brlt, BGE/BGEU = !brlt.
- S_EXEC non-memory instructions: pc_en = 1 (one instruction per cycle).
- LOAD/STORE in S_EXEC:
  - bsel = 1, immsel = I (load) or S (store), ADD.
  - dmem_req = 1, dmem_we = store, pc_en = 0, regwen = 0; next state S_MEM, counter = 0.
- S_MEM:
  - dmem_req and dmem_we stay held; ALU controls stay as in S_EXEC so the address is stable; counter increments each cycle.
  - On dmem_ack: pc_en = 1; for a load, regwen = 1 and wbsel = 0; next state S_EXEC.
  - An ack in the first S_MEM cycle gives 2-cycle memory ops.
- Timeout: counter == MEM_TIMEOUT with no ack → S_ERR, mem_err = 1.
  - If ack arrives on the same cycle as the timeout compare, the ack wins.
- S_ERR: pc_en = 0, regwen = 0, dmem_req = 0; exits only on rst.
- dmem_ack outside S_MEM is ignored.
- Illegal opcode: decoded as a NOP (regwen = 0, pc_en = 1); illegal pulses for that cycle.
- Reset mid-S_MEM: dmem_req drops in the same cycle rst is sampled; the next state is S_EXEC.

Optional Feature:
- Macro DP_CTRL_PERF_EN.
- Defined: adds outputs cycle_cnt[31:0] and instret_cnt[31:0], both reset to 0.
  - cycle_cnt increments every non-reset cycle.
  - instret_cnt increments on every cycle with pc_en = 1.
  - Both wrap at 2^32.
- Undefined: neither the ports nor the counters exist.

Decomposition:
- Package dp_ctrl_pkg holds:
  - opcode constants;
  - immsel, alusel and wbsel encodings;
  - state typedef.
- One sub-module, dp_ctrl_dec: purely combinational inst→control decode.
- dp_ctrl_fsm holds the FSM, counter and stall gating.

Test Plan:
- add x3,x1,x2 (0x002081B3) after reset → same cycle: regwen = 1, wbsel = 1, alusel = 0, bsel = 0, pc_en = 1.
- lw with dmem_ack after 3 cycles → dmem_req high for 4 cycles, pc_en = 0 until the ack cycle; ack cycle: regwen = 1, wbsel = 0, pc_en = 1.
- sw (0x0020A223), ack in the first S_MEM cycle → dmem_we = 1, regwen = 0 throughout, pc_en = 1 exactly on the ack cycle.
- bltu with brlt = 1, then with brlt = 0 → brun = 1, immsel = 2; pcsel = 1, then pcsel = 0.
- lw with no ack → after MEM_TIMEOUT = 16 S_MEM cycles, mem_err = 1 and pc_en stays 0; rst → mem_err = 0, state S_EXEC.
- inst = 0x0000007F → illegal pulses 1 cycle, regwen = 0, pc_en = 1.
